mand_fx_engine: RTL and testbench



---
 rtl/mand_fx_pkg.sv | 48 ++++
 rtl/mand_fx_engine_if.sv | 17 +
 rtl/mand_sync_fifo.sv | 53 +++++
 rtl/mand_fx_engine.sv | 189 ++++++++++++++++++
 tb/tb_mand_fx_engine.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mand_fx_pkg.sv
// Shared definitions for the fixed-point Mandelbrot engine: register map,
// command/status bit positions, engine states and fixed-point helpers.
package mand_fx_pkg;

  localparam logic [2:0] REG_CX      = 3'd0;
  localparam logic [2:0] REG_CY      = 3'd1;
  localparam logic [2:0] REG_TAG     = 3'd2;
  localparam logic [2:0] REG_MAXITER = 3'd3;
  localparam logic [2:0] REG_CMD     = 3'd4;
  localparam logic [2:0] REG_STATUS  = 3'd4;
  localparam logic [2:0] REG_RESULT  = 3'd5;

  localparam int unsigned CMD_PUSH  = 0;
  localparam int unsigned CMD_POP   = 1;
  localparam int unsigned CMD_FLUSH = 2;

  localparam int unsigned ST_BUSY = 16;
  localparam int unsigned ST_OVF  = 17;
  localparam int unsigned ST_UNF  = 18;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MUL   = 3'd2,
    S_STEP  = 3'd3,
    S_WRITE = 3'd4
  } eng_state_t;

  localparam int unsigned FRAC_DEFAULT = 28;
  localparam logic signed [63:0] FOUR = 64'sd4 <<< FRAC_DEFAULT;

  function automatic logic signed [63:0] four_of(input int unsigned frac);
    return 64'sd4 <<< frac;
  endfunction

  // Clamp a wide intermediate to the w-bit signed range.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                             input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mand_fx_engine_if.sv
// Wishbone slave bus plus interrupt line of the Mandelbrot engine.
interface mand_fx_engine_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [2:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        irq_o;

  modport master (output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
                  input  dat_o, ack_o, irq_o);
  modport slave  (input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
                  output dat_o, ack_o, irq_o);
endinterface

// File: rtl/mand_sync_fifo.sv
// Synchronous register-array FIFO with flush; head word is read straight
// from the storage flops, so a pop and the next head are same-cycle.
module mand_sync_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [DW-1:0]          i_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [DW-1:0]          o_head
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_count   = r_cnt;
  assign o_head    = r_mem[r_rd];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + AW'(1);
      if (w_pop_ok)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push_ok && !i_flush) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/mand_fx_engine.sv
// Fixed-point Mandelbrot accelerator: Wishbone register file, job/result
// FIFOs and a sequential MUL/STEP escape-count engine.
module mand_fx_engine
  import mand_fx_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC      = 28,
  parameter int unsigned ITER_W    = 16,
  parameter int unsigned TAG_W     = 16,
  parameter int unsigned IN_DEPTH  = 16,
  parameter int unsigned OUT_DEPTH = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  mand_fx_engine_if.slave wb
);
  localparam int unsigned JW = TAG_W + 2 * WIDTH;
  localparam int unsigned RW = TAG_W + ITER_W;
  localparam int unsigned MW = 2 * WIDTH;
  localparam int unsigned PW = 2 * WIDTH - FRAC;
  localparam logic signed [63:0] C_FOUR = four_of(FRAC);

  logic                     r_ack, r_ovf, r_unf;
  logic [31:0]              r_dat, w_rdata;
  logic [WIDTH-1:0]         r_cx, r_cy;
  logic [TAG_W-1:0]         r_tag, r_jtag;
  logic [ITER_W-1:0]        r_maxiter, r_lim, r_n;
  eng_state_t               r_state;
  logic signed [WIDTH-1:0]  r_x, r_y, r_jcx, r_jcy;
  logic signed [PW-1:0]     r_x2, r_y2, r_xy;
  logic signed [MW-1:0]     w_pxx, w_pyy, w_pxy;
  logic signed [63:0]       w_nx, w_ny;
  logic                     w_esc, w_req, w_wr, w_cmd, w_flush, w_push, w_pop;
  logic                     w_in_full, w_in_empty, w_out_full, w_out_empty;
  logic                     w_eng_pop, w_eng_push, w_unused_sel;
  logic [$clog2(IN_DEPTH):0]  w_in_cnt;
  logic [$clog2(OUT_DEPTH):0] w_out_cnt;
  logic [JW-1:0]            w_in_head;
  logic [RW-1:0]            w_out_head;

  assign w_req   = wb.cyc_i & wb.stb_i & ~r_ack;
  assign w_wr    = w_req & wb.we_i;
  assign w_cmd   = w_wr & (wb.adr_i == REG_CMD);
  assign w_flush = w_cmd & wb.dat_i[CMD_FLUSH];
  assign w_push  = w_cmd & wb.dat_i[CMD_PUSH] & ~wb.dat_i[CMD_FLUSH];
  assign w_pop   = w_cmd & wb.dat_i[CMD_POP] & ~wb.dat_i[CMD_FLUSH];

  assign wb.ack_o     = r_ack;
  assign wb.dat_o     = r_dat;
  assign wb.irq_o     = ~w_out_empty;
  assign w_unused_sel = ^wb.sel_i;
  assign w_eng_pop    = (r_state == S_LOAD);
  assign w_eng_push   = (r_state == S_WRITE);

  always_comb begin
    w_rdata = '0;
    case (wb.adr_i)
      REG_CX:      w_rdata = 32'(r_cx);
      REG_CY:      w_rdata = 32'(r_cy);
      REG_TAG:     w_rdata = 32'(r_tag);
      REG_MAXITER: w_rdata = 32'(r_maxiter);
      REG_STATUS: begin
        w_rdata[7:0]   = 8'(w_in_cnt);
        w_rdata[15:8]  = 8'(w_out_cnt);
        w_rdata[ST_BUSY] = (r_state != S_IDLE);
        w_rdata[ST_OVF]  = r_ovf;
        w_rdata[ST_UNF]  = r_unf;
      end
      REG_RESULT:  if (!w_out_empty) w_rdata = 32'(w_out_head);
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_tag     <= '0;
      r_maxiter <= '1;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_ack <= w_req;
      if (w_req) r_dat <= w_rdata;
      if (w_wr) begin
        case (wb.adr_i)
          REG_CX:      r_cx      <= wb.dat_i[WIDTH-1:0];
          REG_CY:      r_cy      <= wb.dat_i[WIDTH-1:0];
          REG_TAG:     r_tag     <= wb.dat_i[TAG_W-1:0];
          REG_MAXITER: r_maxiter <= wb.dat_i[ITER_W-1:0];
          default: ;
        endcase
      end
      if (w_flush) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end else begin
        if (w_push && w_in_full)  r_ovf <= 1'b1;
        if (w_pop && w_out_empty) r_unf <= 1'b1;
      end
    end
  end

  // All STEP arithmetic runs in 64-bit signed so nothing wraps before sat.
  always_comb begin
    w_pxx = MW'(r_x) * MW'(r_x);
    w_pyy = MW'(r_y) * MW'(r_y);
    w_pxy = MW'(r_x) * MW'(r_y);
    w_esc = ((64'(r_x2) + 64'(r_y2)) > C_FOUR) || (r_n == r_lim);
    w_nx  = sat(64'(r_x2) - 64'(r_y2) + 64'(r_jcx), WIDTH);
    w_ny  = sat(64'(r_xy) + 64'(r_xy) + 64'(r_jcy), WIDTH);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_jcx   <= '0;
      r_jcy   <= '0;
      r_jtag  <= '0;
      r_n     <= '0;
      r_lim   <= '0;
      r_x2    <= '0;
      r_y2    <= '0;
      r_xy    <= '0;
    end else if (w_flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (!w_in_empty && !w_out_full) r_state <= S_LOAD;
        S_LOAD: begin
          {r_jtag, r_jcy, r_jcx} <= w_in_head;
          r_x     <= '0;
          r_y     <= '0;
          r_n     <= '0;
          r_lim   <= r_maxiter;
          r_state <= S_MUL;
        end
        S_MUL: begin
          r_x2    <= PW'(w_pxx >>> FRAC);
          r_y2    <= PW'(w_pyy >>> FRAC);
          r_xy    <= PW'(w_pxy >>> FRAC);
          r_state <= S_STEP;
        end
        S_STEP: begin
          if (w_esc) begin
            r_state <= S_WRITE;
          end else begin
            r_x     <= WIDTH'(w_nx);
            r_y     <= WIDTH'(w_ny);
            r_n     <= r_n + ITER_W'(1);
            r_state <= S_MUL;
          end
        end
        S_WRITE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  mand_sync_fifo #(.DW(JW), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_pop   (w_eng_pop),
    .i_flush (w_flush),
    .i_data  ({r_tag, r_cy, r_cx}),
    .o_full  (w_in_full),
    .o_empty (w_in_empty),
    .o_count (w_in_cnt),
    .o_head  (w_in_head)
  );

  mand_sync_fifo #(.DW(RW), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_eng_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  ({r_jtag, r_n}),
    .o_full  (w_out_full),
    .o_empty (w_out_empty),
    .o_count (w_out_cnt),
    .o_head  (w_out_head)
  );
endmodule

// File: tb/tb_mand_fx_engine.sv
// Scoreboard bench for mand_fx_engine: expected results are queued at job
// push time and a passive bus monitor checks every RESULT read against them.
module tb_mand_fx_engine;
  import mand_fx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mand_fx_engine_if wb ();

  mand_fx_engine #(
    .WIDTH(32), .FRAC(28), .ITER_W(16), .TAG_W(16), .IN_DEPTH(16), .OUT_DEPTH(16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (wb)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Escape count straight from the iteration rule z <- z^2 + c on Q4.28.
  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic logic [15:0] ref_iter(input logic signed [31:0] cx,
                                           input logic signed [31:0] cy,
                                           input logic [15:0] lim);
    longint x = 0;
    longint y = 0;
    longint re2, im2, reim;
    for (int unsigned n = 0; n < lim; n++) begin
      re2  = (x * x) >>> 28;
      im2  = (y * y) >>> 28;
      reim = (x * y) >>> 28;
      if (re2 + im2 > (64'sd4 <<< 28)) return 16'(n);
      x = clamp32(re2 - im2 + longint'(cx));
      y = clamp32(2 * reim + longint'(cy));
    end
    return lim;
  endfunction

  // Passive monitor: latch each request, act on it when ack arrives.
  logic        m_pend = 1'b0;
  logic        m_we;
  logic [2:0]  m_adr;
  logic [31:0] m_dat;
  always @(negedge clk) begin
    if (wb.ack_o && m_pend) begin
      m_pend = 1'b0;
      if (!m_we && m_adr == REG_RESULT)
        check("result", wb.dat_o, (exp_q.size() > 0) ? exp_q[0] : 32'h0);
      else if (m_we && m_adr == REG_CMD && !m_dat[CMD_FLUSH] && m_dat[CMD_POP] && exp_q.size() > 0)
        void'(exp_q.pop_front());
    end else if (wb.cyc_i && wb.stb_i && !wb.ack_o) begin
      m_pend = 1'b1;
      m_we   = wb.we_i;
      m_adr  = wb.adr_i;
      m_dat  = wb.dat_i;
    end
  end

  task automatic bus(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                     output logic [31:0] rd);
    int unsigned t = 0;
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = we;
    wb.adr_i = adr;  wb.dat_i = dat;  wb.sel_i = 4'hF;
    do begin
      @(posedge clk); #1; t++;
    end while (!wb.ack_o && t < 20);
    if (!wb.ack_o) begin
      checks++; errors++;
      $display("FAIL bus_ack: got no ack expected ack within 20 cycles");
    end
    rd = wb.dat_o;
    wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    bus(1'b1, adr, dat, dummy);
  endtask

  task automatic rd(input logic [2:0] adr, output logic [31:0] dat);
    bus(1'b0, adr, 32'h0, dat);
  endtask

  task automatic flush();
    wr(REG_CMD, 32'h4);
    exp_q.delete();
  endtask

  task automatic wait_out(input logic [7:0] n);
    logic [31:0] st;
    int unsigned tries = 0;
    do begin
      rd(REG_STATUS, st); tries++;
    end while (st[15:8] != n && tries < 500);
    if (st[15:8] != n) begin
      checks++; errors++;
      $display("FAIL wait_out: got out count %0d expected %0d", st[15:8], n);
    end
  endtask

  // Push one job on an idle engine, time irq against 2n+5 cycles from the ack.
  task automatic run_job(input logic [31:0] cx, input logic [31:0] cy, input logic [15:0] tag,
                         input logic [31:0] exp_word, input int unsigned exp_cyc);
    logic [31:0] d;
    int unsigned cyc = 0;
    wr(REG_CX, cx); wr(REG_CY, cy); wr(REG_TAG, 32'(tag));
    exp_q.push_back(exp_word);
    wr(REG_CMD, 32'h1);
    while (!wb.irq_o && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
    end
    check("irq_latency", cyc, exp_cyc);
    rd(REG_RESULT, d);
    rd(REG_RESULT, d);
    wr(REG_CMD, 32'h2);
    rd(REG_STATUS, d);
    check("status_after_pop", d, 32'h0);
    check("irq_after_pop", 32'(wb.irq_o), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic signed [31:0] cx, cy;
    logic [15:0] lim;
    int unsigned k;
    wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
    wb.sel_i = 4'h0; wb.adr_i = 3'h0; wb.dat_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(wb.ack_o), 32'h0);
    check("rst_dat", wb.dat_o, 32'h0);
    check("rst_irq", 32'(wb.irq_o), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    rd(REG_STATUS, d);  check("rst_status", d, 32'h0);
    rd(REG_MAXITER, d); check("rst_maxiter", d, 32'h0000FFFF);
    rd(REG_RESULT, d);
    rd(3'd6, d);        check("reg6_zero", d, 32'h0);

    run_job(32'h20000000, 32'h0, 16'h0005, 32'h00050002, 9);
    run_job(32'h10000000, 32'h0, 16'h0007, 32'h00070003, 11);
    wr(REG_MAXITER, 32'd10);
    rd(REG_MAXITER, d); check("maxiter_rw", d, 32'd10);
    run_job(32'h00000000, 32'h0, 16'h0001, 32'h0001000A, 25);
    run_job(32'h80000000, 32'h0, 16'h0002, 32'h00020001, 7);

    // Randomised batches, engine consuming while the host still pushes.
    for (int b = 0; b < 8; b++) begin
      lim = 16'($urandom_range(0, 30));
      wr(REG_MAXITER, 32'(lim));
      k = $urandom_range(1, 4);
      for (int j = 0; j < int'(k); j++) begin
        cx = $signed($urandom) >>> ($urandom_range(1, 2));
        cy = $signed($urandom) >>> ($urandom_range(1, 2));
        wr(REG_CX, cx); wr(REG_CY, cy); wr(REG_TAG, 32'(b * 16 + j));
        exp_q.push_back({16'(b * 16 + j), ref_iter(cx, cy, lim)});
        wr(REG_CMD, 32'h1);
      end
      wait_out(8'(k));
      for (int j = 0; j < int'(k); j++) begin
        rd(REG_RESULT, d);
        wr(REG_CMD, 32'h2);
      end
    end
    rd(REG_STATUS, d); check("status_after_random", d, 32'h0);

    // Fill the output FIFO, then overflow the input FIFO while the engine waits.
    wr(REG_MAXITER, 32'd0);
    wr(REG_CX, 32'h0); wr(REG_CY, 32'h0);
    for (int j = 0; j < 16; j++) begin
      wr(REG_TAG, 32'(16'h100 + j));
      exp_q.push_back({16'(16'h100 + j), 16'h0});
      wr(REG_CMD, 32'h1);
    end
    wait_out(8'd16);
    rd(REG_STATUS, d); check("status_out_full", d, 32'h00001000);
    for (int j = 0; j < 17; j++) wr(REG_CMD, 32'h1);
    rd(REG_STATUS, d); check("status_overflow", d, 32'h00021010);
    check("irq_full", 32'(wb.irq_o), 32'h1);
    flush();
    rd(REG_STATUS, d); check("status_after_flush", d, 32'h0);
    check("irq_after_flush", 32'(wb.irq_o), 32'h0);

    // Drain 16 results, underflow only on the 17th pop.
    for (int j = 0; j < 16; j++) begin
      wr(REG_TAG, 32'(16'h200 + j));
      exp_q.push_back({16'(16'h200 + j), 16'h0});
      wr(REG_CMD, 32'h1);
    end
    wait_out(8'd16);
    for (int j = 0; j < 16; j++) begin
      rd(REG_RESULT, d);
      wr(REG_CMD, 32'h2);
    end
    rd(REG_STATUS, d); check("status_no_underflow", d, 32'h0);
    wr(REG_CMD, 32'h2);
    rd(REG_STATUS, d); check("status_underflow", d, 32'h00040000);
    rd(REG_RESULT, d);

    // Flush an in-flight long job; nothing may come out afterwards.
    flush();
    wr(REG_MAXITER, 32'd1000);
    wr(REG_TAG, 32'h9);
    exp_q.push_back(32'h000903E8);
    wr(REG_CMD, 32'h1);
    repeat (50) @(posedge clk);
    #1;
    rd(REG_STATUS, d); check("status_busy", d, 32'h00010000);
    flush();
    rd(REG_STATUS, d); check("status_flush_midjob", d, 32'h0);
    repeat (2100) @(posedge clk);
    #1;
    rd(REG_STATUS, d); check("status_no_emit", d, 32'h0);
    check("irq_no_emit", 32'(wb.irq_o), 32'h0);
    run_job(32'h20000000, 32'h0, 16'h0011, 32'h00110002, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
